// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: lets the fetch stage (read-only) and the memory stage
// (read/write) share one single-port, multi-cycle SRAM. The memory stage has
// priority. A streak counter stops fetch from being starved.
// Each access goes IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE, and DONE
// pulses the owner's ready for one cycle.
// Optional build macro ARB_STATS_EN adds saturating wait/conflict counters.
//
// state  | meaning
// IDLE   | no access in progress; arbitrate pending requests
// ACCESS | SRAM selected with latched address/data; count down wait cycles
// DONE   | one-cycle ready pulse to the owner; SRAM deselected
module sram_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int WAIT_CYCLES  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_rdata_o,
   output logic              if_ready_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_ready_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_wdata_o,
   input  logic [31:0]       sram_rdata_i,
   output logic              sram_cs_n_o,
   output logic              sram_we_n_o,
   output logic              owner_o,
   output logic              busy_o
`ifdef ARB_STATS_EN
   ,output logic [15:0]      stat_if_wait_o
   ,output logic [15:0]      stat_mem_wait_o
   ,output logic [15:0]      stat_conflicts_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        streak_q, streak_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              grant_mem;
   logic              unused_addr_bits;

   // The byte offset and address bits above the SRAM range are ignored.
   assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                               mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

   // MEM wins any contest unless fetch has already lost STARVE_LIMIT contests in a row.
   assign grant_mem = mem_req_i & ~(if_req_i & (streak_q == LIMIT));

   // State, latched-request and read-data registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         streak_q    <= '0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         streak_q    <= streak_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Next state: arbitration in IDLE, countdown and read capture in ACCESS.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      streak_d    = streak_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         S_IDLE: begin
            // The streak only grows while fetch is actually waiting.
            if (!if_req_i || !grant_mem) begin
               streak_d = '0;
            end else if (streak_q != LIMIT) begin
               streak_d = streak_q + 4'd1;
            end
            if (if_req_i || mem_req_i) begin
               owner_d = grant_mem;
               addr_d  = grant_mem ? mem_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
               we_d    = grant_mem & mem_we_i;
               if (grant_mem) begin
                  wdata_d = mem_wdata_i;
               end
               cnt_d   = CNT_INIT;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!owner_q) begin
                  if_rdata_d = sram_rdata_i;
               end else if (!we_q) begin
                  mem_rdata_d = sram_rdata_i;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sram_cs_n_o  = (state_q != S_ACCESS);
   assign sram_we_n_o  = !((state_q == S_ACCESS) && owner_q && we_q);
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign if_ready_o   = (state_q == S_DONE) && !owner_q;
   assign mem_ready_o  = (state_q == S_DONE) && owner_q;
   assign if_rdata_o   = if_rdata_q;
   assign mem_rdata_o  = mem_rdata_q;
   assign owner_o      = owner_q;
   assign busy_o       = (state_q != S_IDLE);

`ifdef ARB_STATS_EN
   logic [15:0] stat_if_q, stat_mem_q, stat_conf_q;

   // Saturating counters for wait cycles and contested arbitrations.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_if_q   <= '0;
         stat_mem_q  <= '0;
         stat_conf_q <= '0;
      end else begin
         if (if_req_i && !if_ready_o && (stat_if_q != 16'hFFFF)) begin
            stat_if_q <= stat_if_q + 16'd1;
         end
         if (mem_req_i && !mem_ready_o && (stat_mem_q != 16'hFFFF)) begin
            stat_mem_q <= stat_mem_q + 16'd1;
         end
         if ((state_q == S_IDLE) && if_req_i && mem_req_i && (stat_conf_q != 16'hFFFF)) begin
            stat_conf_q <= stat_conf_q + 16'd1;
         end
      end
   end

   assign stat_if_wait_o   = stat_if_q;
   assign stat_mem_wait_o  = stat_mem_q;
   assign stat_conflicts_o = stat_conf_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. The main instance uses default
// parameters. A second instance runs with WAIT_CYCLES=3 for the dropped-request case.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
   logic [31:0] if_rdata, mem_rdata, sram_wdata;
   logic        if_ready, mem_ready, sram_cs_n, sram_we_n, owner, busy;
   logic [15:0] sram_addr;

   logic        w3_if_req, w3_mem_req, w3_mem_we;
   logic [31:0] w3_if_addr, w3_mem_addr, w3_mem_wdata, w3_sram_rdata;
   logic [31:0] w3_if_rdata, w3_mem_rdata, w3_sram_wdata;
   logic        w3_if_ready, w3_mem_ready, w3_sram_cs_n, w3_sram_we_n, w3_owner, w3_busy;
   logic [15:0] w3_sram_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int both_hi_seen = 0;

   always #5 clk = ~clk;

   sram_port_arbiter u_dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
      .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
      .sram_cs_n_o(sram_cs_n), .sram_we_n_o(sram_we_n), .owner_o(owner), .busy_o(busy)
   );

   sram_port_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(w3_if_req), .if_addr_i(w3_if_addr), .if_rdata_o(w3_if_rdata), .if_ready_o(w3_if_ready),
      .mem_req_i(w3_mem_req), .mem_we_i(w3_mem_we), .mem_addr_i(w3_mem_addr), .mem_wdata_i(w3_mem_wdata),
      .mem_rdata_o(w3_mem_rdata), .mem_ready_o(w3_mem_ready),
      .sram_addr_o(w3_sram_addr), .sram_wdata_o(w3_sram_wdata), .sram_rdata_i(w3_sram_rdata),
      .sram_cs_n_o(w3_sram_cs_n), .sram_we_n_o(w3_sram_we_n), .owner_o(w3_owner), .busy_o(w3_busy)
   );

   always @(negedge clk) begin
      if (if_ready && mem_ready) both_hi_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advances on negedges until a ready pulse (or a 40-cycle budget runs out, cyc = -1).
   task automatic run_until_ready(output int cyc, output int cs_low, output int we_low,
                                  output logic [15:0] a_seen, output logic [31:0] wd_seen,
                                  output logic got_if, output logic got_mem);
      cyc = -1; cs_low = 0; we_low = 0; a_seen = '0; wd_seen = '0; got_if = 0; got_mem = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!sram_cs_n) begin
            if (cs_low == 0) begin
               a_seen  = sram_addr;
               wd_seen = sram_wdata;
            end
            cs_low++;
         end
         if (!sram_we_n) we_low++;
         if (if_ready || mem_ready) begin
            cyc = i; got_if = if_ready; got_mem = mem_ready;
            break;
         end
      end
   endtask

   initial begin : stim
      int          cyc, cs_low, we_low, rdy_cnt, rdy_at;
      logic [15:0] a_seen;
      logic [31:0] wd_seen;
      logic        got_if, got_mem;
      logic [5:0]  exp_pat;

      rst = 1'b1;
      if_req = 0; mem_req = 0; mem_we = 0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
      w3_if_req = 0; w3_mem_req = 0; w3_mem_we = 0;
      w3_if_addr = '0; w3_mem_addr = '0; w3_mem_wdata = '0; w3_sram_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(sram_cs_n), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_ready", 32'({if_ready, mem_ready}), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // IF read alone
      if_req = 1; if_addr = 32'h0000_0010; sram_rdata = 32'hE3A0_1005;
      run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
      check("if_lat", 32'(cyc), 32'd3);
      check("if_cs_len", 32'(cs_low), 32'd2);
      check("if_we_len", 32'(we_low), 32'd0);
      check("if_addr", 32'(a_seen), 32'h0004);
      check("if_got", 32'({got_if, got_mem}), 32'b10);
      check("if_rdata", if_rdata, 32'hE3A0_1005);
      check("if_owner", 32'(owner), 32'd0);
      if_req = 0;
      @(negedge clk);
      check("if_pulse_end", 32'({if_ready, busy}), 32'd0);

      // Simultaneous IF and MEM reads: MEM first, IF 4 cycles later
      if_req = 1; if_addr = 32'h0000_0020;
      mem_req = 1; mem_we = 0; mem_addr = 32'hFFFC_0807; sram_rdata = 32'h1111_2222;
      run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
      check("both_mem_lat", 32'(cyc), 32'd3);
      check("both_mem_got", 32'({got_if, got_mem}), 32'b01);
      check("both_mem_owner", 32'(owner), 32'd1);
      check("both_mem_addr", 32'(a_seen), 32'h0201);
      check("both_mem_rdata", mem_rdata, 32'h1111_2222);
      mem_req = 0; sram_rdata = 32'h3333_4444;
      run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
      check("both_if_gap", 32'(cyc), 32'd4);
      check("both_if_got", 32'({got_if, got_mem}), 32'b10);
      check("both_if_addr", 32'(a_seen), 32'h0008);
      check("both_if_rdata", if_rdata, 32'h3333_4444);
      check("both_mem_hold", mem_rdata, 32'h1111_2222);
      if_req = 0;
      @(negedge clk);

      // MEM write alone
      mem_req = 1; mem_we = 1; mem_addr = 32'h0000_0400; mem_wdata = 32'hDEAD_BEEF;
      sram_rdata = 32'h1234_5678;
      run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
      check("wr_lat", 32'(cyc), 32'd3);
      check("wr_cs_len", 32'(cs_low), 32'd2);
      check("wr_we_len", 32'(we_low), 32'd2);
      check("wr_addr", 32'(a_seen), 32'h0100);
      check("wr_wdata", wd_seen, 32'hDEAD_BEEF);
      check("wr_got", 32'({got_if, got_mem}), 32'b01);
      check("wr_rdata_kept", mem_rdata, 32'h1111_2222);
      mem_req = 0; mem_we = 0;
      @(negedge clk);
      check("wr_we_n_idle", 32'(sram_we_n), 32'd1);

      // Starvation guard: 4 MEM grants, then IF, then MEM again
      exp_pat = 6'b101111;
      if_req = 1; if_addr = 32'h0000_0040; mem_req = 1; mem_addr = 32'h0000_0080;
      for (int k = 0; k < 6; k++) begin
         run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
         check($sformatf("starve_lat%0d", k), 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
         check($sformatf("starve_mem%0d", k), 32'(got_mem), 32'(exp_pat[k]));
         if (got_if) if_req = 0;
      end
      mem_req = 0;
      @(negedge clk);

      // Async reset in the middle of an access
      mem_req = 1; mem_we = 0; mem_addr = 32'h0000_0200; sram_rdata = 32'hAAAA_5555;
      @(negedge clk);
      check("rst_mid_cs_before", 32'(sram_cs_n), 32'd0);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_cs", 32'(sram_cs_n), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_addr", 32'(sram_addr), 32'd0);
      check("rst_mid_rdata", mem_rdata | if_rdata, 32'd0);
      mem_req = 0;
      rdy_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (if_ready || mem_ready) rdy_cnt++;
      end
      check("rst_mid_no_ready", 32'(rdy_cnt), 32'd0);
      rst = 1'b0;
      if_req = 1; if_addr = 32'h0000_0014; sram_rdata = 32'h0C0F_FEE0;
      run_until_ready(cyc, cs_low, we_low, a_seen, wd_seen, got_if, got_mem);
      check("post_rst_lat", 32'(cyc), 32'd3);
      check("post_rst_addr", 32'(a_seen), 32'h0005);
      check("post_rst_rdata", if_rdata, 32'h0C0F_FEE0);
      if_req = 0;
      @(negedge clk);

      // WAIT_CYCLES=3 instance: mem_req dropped during ACCESS
      w3_mem_req = 1; w3_mem_we = 0; w3_mem_addr = 32'h0000_000C; w3_sram_rdata = 32'h0BAD_F00D;
      cs_low = 0; rdy_cnt = 0; rdy_at = -1; a_seen = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!w3_sram_cs_n) begin
            cs_low++;
            a_seen = w3_sram_addr;
         end
         if (w3_mem_ready) begin
            rdy_cnt++;
            rdy_at = i;
         end
         if (i == 1) w3_mem_req = 0;
      end
      check("w3_cs_len", 32'(cs_low), 32'd3);
      check("w3_ready_cnt", 32'(rdy_cnt), 32'd1);
      check("w3_ready_at", 32'(rdy_at), 32'd4);
      check("w3_addr", 32'(a_seen), 32'h0003);
      check("w3_rdata", w3_mem_rdata, 32'h0BAD_F00D);
      check("w3_idle_end", 32'(w3_busy), 32'd0);

      check("never_both_ready", 32'(both_hi_seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
